// File: rtl/register_writeback_unit.sv
// Register write-back: arbitrates ALU results and FIFO-buffered load results onto the single
// register-file write port. Define WB_SCOREBOARD_EN to build the pending-load scoreboard.
module register_writeback_unit #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [3:0]                    alu_rd,
    input  logic [15:0]                   alu_data,
    output logic                          alu_ready,
    input  logic                          mem_valid,
    input  logic [3:0]                    mem_rd,
    input  logic [15:0]                   mem_data,
    output logic                          mem_ready,
    input  logic                          issue_valid,
    input  logic [3:0]                    issue_rd,
    output logic [15:0]                   r,
    output logic [15:0]                   en,
    output logic [15:0]                   pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [3:0]       r_fifo_rd   [FIFO_DEPTH];
    logic [15:0]      r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_wdata;
    logic [15:0]      r_wen;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_alu_wr;
    logic [3:0]       w_head_rd;
    logic [15:0]      w_head_data;

    // A full FIFO takes priority so sustained ALU traffic cannot deadlock the load path.
    always_comb begin
        w_full      = (r_count == DEPTH_CNT);
        w_empty     = (r_count == '0);
        mem_ready   = !rst && !w_full;
        alu_ready   = !rst && !w_full;
        w_push      = mem_valid && mem_ready;
        w_pop       = !rst && (w_full || (!alu_valid && !w_empty));
        w_alu_wr    = alu_valid && alu_ready;
        w_head_rd   = r_fifo_rd[r_rd_ptr];
        w_head_data = r_fifo_data[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= mem_rd;
            r_fifo_data[r_wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wdata  <= '0;
            r_wen    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_wen   <= 16'h0001 << w_head_rd;
                r_wdata <= w_head_data;
            end else if (w_alu_wr) begin
                r_wen   <= 16'h0001 << alu_rd;
                r_wdata <= alu_data;
            end else begin
                r_wen   <= '0;
            end
        end
    end

    assign r          = r_wdata;
    assign en         = r_wen;
    assign fifo_count = r_count;

`ifdef WB_SCOREBOARD_EN
    logic [15:0] r_pending;
    logic [15:0] w_sb_set;
    logic [15:0] w_sb_clr;

    // Set is applied after clear so a same-cycle issue to the popped register stays pending.
    always_comb begin
        w_sb_set = issue_valid ? (16'h0001 << issue_rd) : 16'h0000;
        w_sb_clr = w_pop ? (16'h0001 << w_head_rd) : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_sb_clr) | w_sb_set;
        end
    end

    assign pending = r_pending;
`else
    logic w_unused_issue;
    assign w_unused_issue = ^{issue_valid, issue_rd};
    assign pending        = 16'h0000;
`endif

endmodule

// File: tb/tb_register_writeback_unit.sv
// Bench for register_writeback_unit: directed vector table followed by random traffic
// checked against a queue-based reference model.
module tb_register_writeback_unit;

    localparam int unsigned DEPTH = 4;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [3:0]  issue_rd;
    logic [15:0] r;
    logic [15:0] en;
    logic [15:0] pending;
    logic [2:0]  fifo_count;

    register_writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .r           (r),
        .en          (en),
        .pending     (pending),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [3:0]  ard;
        logic [15:0] adat;
        logic        mv;
        logic [3:0]  mrd;
        logic [15:0] mdat;
        logic        iv;
        logic [3:0]  ird;
        logic        e_ard;
        logic        e_mrd;
        logic [15:0] e_en;
        logic [15:0] e_r;
        logic [2:0]  e_cnt;
        logic [15:0] e_pend;
    } vec_t;

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] data;
    } ent_t;

    int nvec = 0;
    int nerr = 0;

    ent_t        mq[$];
    logic [15:0] m_en   = 16'h0;
    logic [15:0] m_r    = 16'h0;
    logic [15:0] m_pend = 16'h0;

    vec_t tbl[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one edge of the write port, from the arbitration rules directly.
    task automatic model_edge();
        bit   full;
        bit   pop;
        ent_t e;
        full = (mq.size() == DEPTH);
        if (rst) begin
            mq.delete();
            m_en   = 16'h0;
            m_r    = 16'h0;
            m_pend = 16'h0;
            return;
        end
        pop = full || (!alu_valid && mq.size() != 0);
        if (pop) begin
            e            = mq.pop_front();
            m_en         = 16'h1 << e.rd;
            m_r          = e.data;
            m_pend[e.rd] = 1'b0;
        end else if (alu_valid) begin
            m_en = 16'h1 << alu_rd;
            m_r  = alu_data;
        end else begin
            m_en = 16'h0;
        end
        if (mem_valid && !full) mq.push_back({mem_rd, mem_data});
        if (issue_valid) m_pend[issue_rd] = 1'b1;
    endtask

    task automatic cycle(input bit use_tbl, input string tag, input vec_t v);
        logic exp_rdy;
        rst         = v.rst;
        alu_valid   = v.av;
        alu_rd      = v.ard;
        alu_data    = v.adat;
        mem_valid   = v.mv;
        mem_rd      = v.mrd;
        mem_data    = v.mdat;
        issue_valid = v.iv;
        issue_rd    = v.ird;
        #1;
        exp_rdy = !rst && (mq.size() != DEPTH);
        check({tag, " alu_ready"}, 32'(alu_ready), 32'(exp_rdy));
        check({tag, " mem_ready"}, 32'(mem_ready), 32'(exp_rdy));
        if (use_tbl) begin
            check({tag, " tbl alu_ready"}, 32'(alu_ready), 32'(v.e_ard));
            check({tag, " tbl mem_ready"}, 32'(mem_ready), 32'(v.e_mrd));
        end
        model_edge();
        @(posedge clk);
        #1;
        check({tag, " en"}, 32'(en), 32'(m_en));
        check({tag, " r"}, 32'(r), 32'(m_r));
        check({tag, " fifo_count"}, 32'(fifo_count), 32'(mq.size()));
        check({tag, " pending"}, 32'(pending), 32'(SB ? m_pend : 16'h0));
        if (use_tbl) begin
            check({tag, " tbl en"}, 32'(en), 32'(v.e_en));
            check({tag, " tbl r"}, 32'(r), 32'(v.e_r));
            check({tag, " tbl fifo_count"}, 32'(fifo_count), 32'(v.e_cnt));
            check({tag, " tbl pending"}, 32'(pending), 32'(SB ? v.e_pend : 16'h0));
        end
    endtask

    initial begin
        vec_t v;
        int   alu_pct;
        rst = 1'b1; alu_valid = 1'b0; alu_rd = 4'd0; alu_data = 16'h0;
        mem_valid = 1'b0; mem_rd = 4'd0; mem_data = 16'h0;
        issue_valid = 1'b0; issue_rd = 4'd0;

        // {rst,av,ard,adat,mv,mrd,mdat,iv,ird, e_ard,e_mrd,e_en,e_r,e_cnt,e_pend}
        tbl[0]  = '{1'b1,1'b1,4'd0,16'h0001,1'b1,4'd0,16'h0002,1'b1,4'd0,
                    1'b0,1'b0,16'h0000,16'h0000,3'd0,16'h0000};
        tbl[1]  = tbl[0];
        tbl[2]  = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,16'h0000,1'b0,4'd0,
                    1'b1,1'b1,16'h0000,16'h0000,3'd0,16'h0000};
        tbl[3]  = '{1'b0,1'b1,4'd3,16'hBEEF,1'b0,4'd0,16'h0000,1'b0,4'd0,
                    1'b1,1'b1,16'h0008,16'hBEEF,3'd0,16'h0000};
        tbl[4]  = tbl[2]; tbl[4].e_r = 16'hBEEF;
        tbl[5]  = '{1'b0,1'b1,4'd1,16'h1111,1'b1,4'd2,16'h2222,1'b0,4'd0,
                    1'b1,1'b1,16'h0002,16'h1111,3'd1,16'h0000};
        tbl[6]  = tbl[2]; tbl[6].e_en = 16'h0004; tbl[6].e_r = 16'h2222;
        tbl[7]  = tbl[2]; tbl[7].e_r = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            tbl[8+i] = '{1'b0,1'b1,4'd10,16'h00A0 + 16'(i),1'b1,4'(4+i),16'h4444 * 16'(i+1),
                         1'b0,4'd0,1'b1,1'b1,16'h0400,16'h00A0 + 16'(i),3'(i+1),16'h0000};
        end
        tbl[12] = '{1'b0,1'b1,4'd11,16'h00B0,1'b0,4'd0,16'h0000,1'b0,4'd0,
                    1'b0,1'b0,16'h0010,16'h4444,3'd3,16'h0000};
        tbl[13] = tbl[12]; tbl[13].e_ard = 1'b1; tbl[13].e_mrd = 1'b1;
        tbl[13].e_en = 16'h0800; tbl[13].e_r = 16'h00B0;
        tbl[14] = tbl[2]; tbl[14].e_en = 16'h0020; tbl[14].e_r = 16'h8888; tbl[14].e_cnt = 3'd2;
        tbl[15] = tbl[2]; tbl[15].e_en = 16'h0040; tbl[15].e_r = 16'hCCCC; tbl[15].e_cnt = 3'd1;
        tbl[16] = tbl[2]; tbl[16].e_en = 16'h0080; tbl[16].e_r = 16'h1110;
        tbl[17] = tbl[2]; tbl[17].e_r = 16'h1110;
        tbl[18] = tbl[17]; tbl[18].iv = 1'b1; tbl[18].ird = 4'd9; tbl[18].e_pend = 16'h0200;
        tbl[19] = tbl[17]; tbl[19].mv = 1'b1; tbl[19].mrd = 4'd9; tbl[19].mdat = 16'h9999;
        tbl[19].e_cnt = 3'd1; tbl[19].e_pend = 16'h0200;
        tbl[20] = tbl[2]; tbl[20].e_en = 16'h0200; tbl[20].e_r = 16'h9999;
        tbl[21] = tbl[2]; tbl[21].mv = 1'b1; tbl[21].mrd = 4'd9; tbl[21].mdat = 16'h9A9A;
        tbl[21].iv = 1'b1; tbl[21].ird = 4'd9; tbl[21].e_r = 16'h9999;
        tbl[21].e_cnt = 3'd1; tbl[21].e_pend = 16'h0200;
        tbl[22] = tbl[2]; tbl[22].iv = 1'b1; tbl[22].ird = 4'd9; tbl[22].e_en = 16'h0200;
        tbl[22].e_r = 16'h9A9A; tbl[22].e_pend = 16'h0200;
        tbl[23] = tbl[2]; tbl[23].mv = 1'b1; tbl[23].mrd = 4'd9; tbl[23].mdat = 16'h9B9B;
        tbl[23].e_r = 16'h9A9A; tbl[23].e_cnt = 3'd1; tbl[23].e_pend = 16'h0200;
        tbl[24] = tbl[2]; tbl[24].e_en = 16'h0200; tbl[24].e_r = 16'h9B9B;
        for (int i = 0; i < 4; i++) begin
            tbl[25+i] = '{1'b0,1'b1,4'd1,16'(i+1),(i < 3),4'(4+i),16'hC004 + 16'(i),1'b1,4'(4+i),
                          1'b1,1'b1,16'h0002,16'(i+1),(i < 3) ? 3'(i+1) : 3'd3,
                          16'((32'h1 << (i+5)) - 32'h10)};
        end
        tbl[29] = tbl[2]; tbl[29].rst = 1'b1; tbl[29].e_ard = 1'b0; tbl[29].e_mrd = 1'b0;
        tbl[30] = tbl[2];
        tbl[31] = tbl[2];

        for (int i = 0; i < 32; i++) cycle(1'b1, $sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 3000; i++) begin
            alu_pct = ((i / 300) % 2 == 1) ? 92 : 40;
            v       = tbl[2];
            v.rst   = ($urandom_range(0, 99) == 0);
            v.av    = ($urandom_range(0, 99) < alu_pct);
            v.ard   = 4'($urandom);
            v.adat  = 16'($urandom);
            v.mv    = ($urandom_range(0, 99) < 60);
            v.mrd   = 4'($urandom);
            v.mdat  = 16'($urandom);
            v.iv    = ($urandom_range(0, 99) < 30);
            v.ird   = 4'($urandom);
            cycle(1'b0, $sformatf("rnd%0d", i), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
